operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_pkg.sv | 11 +
 rtl/nibble_shift_reg.sv | 32 +++
 rtl/operand_loader.sv | 109 ++++++++++
 tb/tb_operand_loader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and default widths for the operand loader.
package operand_loader_pkg;
  localparam int K_DEF   = 16;
  localparam int NIB_DEF = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_shift_reg.sv
// K-bit shift register that takes NIB-bit chunks on its LSB side, MS chunk first.
// nxt_o shows the value after a shift so the parent can capture a just-completed operand.
module nibble_shift_reg
  import operand_loader_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int NIB = NIB_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           ld_i,
  input  logic [NIB-1:0] din_i,
  output logic [K-1:0]   q_o,
  output logic [K-1:0]   nxt_o
);
  logic [K-1:0] sh_q, sh_d;

  assign nxt_o = (sh_q << NIB) | K'(din_i);
  assign q_o   = sh_q;

  always_comb begin
    sh_d = sh_q;
    if (clr_i)     sh_d = '0;
    else if (ld_i) sh_d = nxt_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end
endmodule

// File: rtl/operand_loader.sv
// Assembles operand pairs A then B from a chunk stream and holds them until acked.
// Define OPERAND_LOADER_PAIRCOUNT_EN to add an 8-bit pairCount output of accepted acks.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int NIB = NIB_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIB-1:0] nibbleIn,
  input  logic           nibbleValid,
  output logic           nibbleReady,
  output logic [K-1:0]   inputA,
  output logic [K-1:0]   inputB,
  output logic           operandsValid,
  input  logic           operandsAck,
  output logic           busy
`ifdef OPERAND_LOADER_PAIRCOUNT_EN
  ,
  output logic [7:0]     pairCount
`endif
);
  localparam int N     = K / NIB;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [K-1:0]       a_q, a_d, b_q, b_d;
  logic [K-1:0]       sha_q, sha_nxt, shb_q, shb_nxt;
  logic               xfer, last, ld_a, ld_b, ack_take;

  assign xfer     = nibbleValid && nibbleReady;
  assign last     = (cnt_q == CNT_W'(N - 1));
  assign ld_a     = xfer && (state_q == LOAD_A);
  assign ld_b     = xfer && (state_q == LOAD_B);
  assign ack_take = operandsAck && (state_q == PRESENT);

  nibble_shift_reg #(.K(K), .NIB(NIB)) u_sh_a (
    .clk(clk), .rst_n(rst_n), .clr_i(ack_take), .ld_i(ld_a),
    .din_i(nibbleIn), .q_o(sha_q), .nxt_o(sha_nxt)
  );

  nibble_shift_reg #(.K(K), .NIB(NIB)) u_sh_b (
    .clk(clk), .rst_n(rst_n), .clr_i(ack_take), .ld_i(ld_b),
    .din_i(nibbleIn), .q_o(shb_q), .nxt_o(shb_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD_A: if (xfer) begin
        if (last) begin
          state_d = LOAD_B;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      LOAD_B: if (xfer) begin
        if (last) begin
          // A is already complete; B's final chunk arrives on this edge.
          state_d = PRESENT;
          cnt_d   = '0;
          a_d     = sha_q;
          b_d     = shb_nxt;
        end else cnt_d = cnt_q + 1'b1;
      end
      PRESENT: if (operandsAck) begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign nibbleReady   = (state_q != PRESENT);
  assign operandsValid = (state_q == PRESENT);
  assign busy          = (state_q != LOAD_A) || (cnt_q != '0);
  assign inputA        = a_q;
  assign inputB        = b_q;

`ifdef OPERAND_LOADER_PAIRCOUNT_EN
  logic [7:0] pc_q;
  always_ff @(posedge clk) begin
    if (!rst_n)        pc_q <= '0;
    else if (ack_take) pc_q <= pc_q + 8'd1;
  end
  assign pairCount = pc_q;
`endif
endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench: randomized and directed chunk streams against a chunk-count reference model.
module tb_operand_loader;
  localparam int K   = 16;
  localparam int NIB = 4;
  localparam int N   = K / NIB;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NIB-1:0] nibbleIn;
  logic           nibbleValid;
  logic           nibbleReady;
  logic [K-1:0]   inputA, inputB;
  logic           operandsValid;
  logic           operandsAck;
  logic           busy;
`ifdef OPERAND_LOADER_PAIRCOUNT_EN
  logic [7:0]     pairCount;
`endif

  operand_loader #(.K(K), .NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .nibbleIn(nibbleIn), .nibbleValid(nibbleValid),
    .nibbleReady(nibbleReady), .inputA(inputA), .inputB(inputB),
    .operandsValid(operandsValid), .operandsAck(operandsAck), .busy(busy)
`ifdef OPERAND_LOADER_PAIRCOUNT_EN
    , .pairCount(pairCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: chunks taken so far in the current pair (0..2N-1), accumulators, presented pair.
  int           m_taken;
  logic [K-1:0] m_acc_a, m_acc_b, m_out_a, m_out_b;
  bit           m_pres;
  logic [7:0]   m_pc;

  task automatic model_step(input logic r, input logic v, input logic [NIB-1:0] n, input logic a);
    if (!r) begin
      m_taken = 0; m_acc_a = '0; m_acc_b = '0; m_out_a = '0; m_out_b = '0; m_pres = 0; m_pc = '0;
    end else if (m_pres) begin
      if (a) begin
        m_pres = 0;
        m_pc   = m_pc + 8'd1;
      end
    end else if (v) begin
      if (m_taken < N) m_acc_a = (m_acc_a << NIB) | K'(n);
      else             m_acc_b = (m_acc_b << NIB) | K'(n);
      m_taken++;
      if (m_taken == 2 * N) begin
        m_pres = 1; m_out_a = m_acc_a; m_out_b = m_acc_b; m_taken = 0;
        m_acc_a = '0; m_acc_b = '0;
      end
    end
  endtask

  task automatic check_model();
    logic exp_rdy, exp_vld, exp_busy;
    exp_rdy  = !m_pres;
    exp_vld  = m_pres;
    exp_busy = m_pres || (m_taken > 0);
    checks++;
    if (nibbleReady !== exp_rdy || operandsValid !== exp_vld || busy !== exp_busy ||
        inputA !== m_out_a || inputB !== m_out_b) begin
      failures++;
      $display("FAIL cycle_model t=%0t got rdy=%b vld=%b busy=%b A=%h B=%h want rdy=%b vld=%b busy=%b A=%h B=%h",
               $time, nibbleReady, operandsValid, busy, inputA, inputB,
               exp_rdy, exp_vld, exp_busy, m_out_a, m_out_b);
    end
`ifdef OPERAND_LOADER_PAIRCOUNT_EN
    checks++;
    if (pairCount !== m_pc) begin
      failures++;
      $display("FAIL pair_count t=%0t got %0d want %0d", $time, pairCount, m_pc);
    end
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare at negedge.
  task automatic cyc(input logic r, input logic v, input logic [NIB-1:0] n, input logic a);
    rst_n = r; nibbleValid = v; nibbleIn = n; operandsAck = a;
    model_step(r, v, n, a);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic send(input logic [NIB-1:0] n);
    cyc(1'b1, 1'b1, n, 1'b0);
  endtask

  initial begin
    logic [NIB-1:0] seq [8];
    rst_n = 1'b0; nibbleValid = 1'b0; nibbleIn = '0; operandsAck = 1'b0;
    m_taken = 0; m_pres = 0; m_acc_a = '0; m_acc_b = '0; m_out_a = '0; m_out_b = '0; m_pc = '0;

    // Reset state
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    chk("reset_ready", {31'd0, nibbleReady}, 32'd1);
    chk("reset_outs", {13'd0, operandsValid, busy, 1'b0, inputA}, 32'd0);
    chk("reset_B", {16'd0, inputB}, 32'd0);

    // Back-to-back F,F,F,F,A,A,A,A
    seq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'hA, 4'hA};
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      if (i < 7) chk("b2b_not_yet_valid", {31'd0, operandsValid}, 32'd0);
    end
    chk("b2b_valid", {31'd0, operandsValid}, 32'd1);
    chk("b2b_A", {16'd0, inputA}, 32'h0000FFFF);
    chk("b2b_B", {16'd0, inputB}, 32'h0000AAAA);
    chk("b2b_xnor", {16'd0, ~(inputA ^ inputB)}, 32'h0000AAAA);

    // Backpressure: 5 cycles of valid chunks with no ack
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 4'h3, 1'b0);
      chk("bp_ready_low", {31'd0, nibbleReady}, 32'd0);
      chk("bp_hold", {inputA, inputB}, 32'hFFFFAAAA);
    end
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    chk("ack_valid_low", {31'd0, operandsValid}, 32'd0);
    chk("ack_ready_high", {31'd0, nibbleReady}, 32'd1);
    chk("ack_keep_pair", {inputA, inputB}, 32'hFFFFAAAA);

    // Gapped input 1..8, spurious ack during the load
    for (int i = 1; i <= 8; i++) begin
      send(NIB'(i));
      cyc(1'b1, 1'b0, 4'hE, 1'b1);
    end
    chk("gap_A", {16'd0, inputA}, 32'h00001234);
    chk("gap_B", {16'd0, inputB}, 32'h00005678);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);

    // Reset after 6 chunks, then reload
    for (int i = 0; i < 6; i++) send(4'h9);
    cyc(1'b0, 1'b1, 4'h9, 1'b1);
    chk("midrst_outs", {13'd0, operandsValid, busy, 1'b0, inputA}, 32'd0);
    chk("midrst_ready", {31'd0, nibbleReady}, 32'd1);
    seq = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2};
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, seq[i], 1'b1);
    chk("reload_pair", {inputA, inputB}, 32'h00010002);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
          NIB'($urandom), ($urandom_range(0, 2) == 0));
    end

`ifdef OPERAND_LOADER_PAIRCOUNT_EN
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    chk("pc_reset", {24'd0, pairCount}, 32'd0);
    for (int p = 0; p < 256; p++) begin
      for (int j = 0; j < 2 * N; j++) send(NIB'($urandom));
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
    end
    chk("pc_wrap", {24'd0, pairCount}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
